// File: rtl/rv32i_types.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32i_types : shared RV32I opcode/funct3 encodings and LSU state type
// Revision    : 1.0
// ---------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    DONE = 3'd3,
    FLT  = 3'd4
  } lsu_state_t;

  // True when a request must be rejected: misaligned or unknown width encoding.
  function automatic logic lsu_req_fault(input logic is_store,
                                         input logic [2:0] f3,
                                         input logic [1:0] off);
    logic flt;
    flt = 1'b1;
    if (is_store) begin
      case (f3)
        sb:      flt = 1'b0;
        sh:      flt = off[0];
        sw:      flt = (off != 2'b00);
        default: flt = 1'b1;
      endcase
    end else begin
      case (f3)
        lb, lbu: flt = 1'b0;
        lh, lhu: flt = off[0];
        lw:      flt = (off != 2'b00);
        default: flt = 1'b1;
      endcase
    end
    return flt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_align : byte-lane steering for stores and extension for loads
// Revision  : 1.0
// ---------------------------------------------------------------------------
module lsu_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    wdata   = store_data << {byte_off, 3'b000};

    case (funct3)
      sb:      wmask = 4'b0001 << byte_off;
      sh:      wmask = 4'b0011 << byte_off;
      default: wmask = 4'b1111;
    endcase

    case (funct3)
      lb:      load_ext = {{24{shifted[7]}}, shifted[7:0]};
      lh:      load_ext = {{16{shifted[15]}}, shifted[15:0]};
      lbu:     load_ext = {24'h0, shifted[7:0]};
      lhu:     load_ext = {16'h0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lsu_ctrl : load/store sequencer between the main control FSM and memory
// Revision : 1.0
// ---------------------------------------------------------------------------
module lsu_ctrl
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  rv32i_opcode opcode,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  lsu_state_t  state, state_next;
  logic        capture;
  logic        is_load, is_store, req_fault;
  logic [31:0] addr_q, store_data_q;
  logic [2:0]  funct3_q;
  rv32i_opcode opcode_q;
  logic [3:0]  wmask_raw;
  logic [31:0] load_ext;

  assign is_load   = (opcode == op_load);
  assign is_store  = (opcode == op_store);
  assign req_fault = lsu_req_fault(is_store, funct3, addr[1:0]);

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start && (is_load || is_store)) begin
          capture = 1'b1;
          if (req_fault)    state_next = FLT;
          else if (is_load) state_next = RD;
          else              state_next = WR;
        end
      end
      RD, WR:    if (mem_resp) state_next = DONE;
      DONE, FLT: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= 32'h0;
      store_data_q <= 32'h0;
      funct3_q     <= 3'h0;
      opcode_q     <= rv32i_opcode'(7'h0);
      load_data    <= 32'h0;
    end else begin
      state <= state_next;
      if (capture) begin
        addr_q       <= addr;
        store_data_q <= store_data;
        funct3_q     <= funct3;
        opcode_q     <= opcode;
      end
      if (state == RD && mem_resp && opcode_q == op_load)
        load_data <= load_ext;
    end
  end

  lsu_align u_align (
    .funct3     (funct3_q),
    .byte_off   (addr_q[1:0]),
    .store_data (store_data_q),
    .rdata      (mem_rdata),
    .wmask      (wmask_raw),
    .wdata      (mem_wdata),
    .load_ext   (load_ext)
  );

  // Strobes and status decode straight from the state register (glitch-free).
  assign mem_address = {addr_q[31:2], 2'b00};
  assign mem_read    = (state == RD);
  assign mem_write   = (state == WR);
  assign mem_wmask   = (state == WR) ? wmask_raw : 4'b0000;
  assign busy        = (state != IDLE);
  assign done        = (state == DONE) || (state == FLT);
  assign fault       = (state == FLT);

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lsu_ctrl : table-driven self-checking bench with a result scoreboard
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  rv32i_opcode opcode;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, mem_rdata;
  logic        mem_resp;
  logic [31:0] mem_address, mem_wdata, load_data;
  logic        mem_read, mem_write, busy, done, fault;
  logic [3:0]  mem_wmask;

  int total  = 0;
  int passed = 0;

  typedef struct {
    rv32i_opcode op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          waits;
    logic        exp_fault;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  typedef struct {
    logic        fault;
    logic [31:0] load;
  } exp_t;

  vec_t vecs[12];
  exp_t scb_q[$];

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .opcode      (opcode),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .mem_resp    (mem_resp),
    .mem_rdata   (mem_rdata),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wmask   (mem_wmask),
    .mem_wdata   (mem_wdata),
    .load_data   (load_data),
    .busy        (busy),
    .done        (done),
    .fault       (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed++;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    logic is_ld;
    is_ld = (v.op == op_load);
    @(negedge clk);
    start = 1'b1; opcode = v.op; funct3 = v.f3; addr = v.addr; store_data = v.sd;
    scb_q.push_back('{v.exp_fault, v.exp_load});
    @(negedge clk);
    // Scramble request inputs: the DUT must work from its captured copy.
    start = 1'b0; opcode = op_imm; funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
    if (v.exp_fault) begin
      check($sformatf("v%0d flt_read", idx), 32'(mem_read), 32'd0);
      check($sformatf("v%0d flt_write", idx), 32'(mem_write), 32'd0);
      check($sformatf("v%0d flt_done", idx), 32'(done), 32'd1);
      e = scb_q.pop_front();
      check($sformatf("v%0d flt_fault", idx), 32'(fault), 32'(e.fault));
      check($sformatf("v%0d flt_load_hold", idx), load_data, e.load);
    end else begin
      check($sformatf("v%0d read", idx), 32'(mem_read), 32'(is_ld));
      check($sformatf("v%0d write", idx), 32'(mem_write), 32'(!is_ld));
      check($sformatf("v%0d address", idx), mem_address, v.exp_addr);
      check($sformatf("v%0d wmask", idx), 32'(mem_wmask), 32'(v.exp_wmask));
      if (!is_ld) check($sformatf("v%0d wdata", idx), mem_wdata, v.exp_wdata);
      repeat (v.waits) begin
        @(negedge clk);
        check($sformatf("v%0d strobe_held", idx), 32'(mem_read | mem_write), 32'd1);
        check($sformatf("v%0d early_done", idx), 32'(done), 32'd0);
      end
      mem_resp = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_resp = 1'b0; mem_rdata = $urandom;
      e = scb_q.pop_front();
      check($sformatf("v%0d done", idx), 32'(done), 32'd1);
      check($sformatf("v%0d fault", idx), 32'(fault), 32'(e.fault));
      check($sformatf("v%0d strobe_off", idx), 32'(mem_read | mem_write), 32'd0);
      check($sformatf("v%0d load_data", idx), load_data, e.load);
    end
    @(negedge clk);
    check($sformatf("v%0d done_pulse", idx), 32'(done), 32'd0);
    check($sformatf("v%0d idle", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          op        f3      addr          sd            rdata         w  flt  exp_addr      wmask    exp_wdata     exp_load
    vecs[0]  = '{op_load,  3'b010, 32'h00000100, 32'h0,        32'hDEADBEEF, 3, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{op_load,  3'b000, 32'h00000103, 32'h0,        32'h80112233, 1, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{op_load,  3'b100, 32'h00000103, 32'h0,        32'h80112233, 1, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'h00000080};
    vecs[3]  = '{op_load,  3'b001, 32'h00000102, 32'h0,        32'h80011234, 2, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'hFFFF8001};
    vecs[4]  = '{op_load,  3'b101, 32'h00000102, 32'h0,        32'h80011234, 0, 1'b0, 32'h00000100, 4'b0000, 32'h0,        32'h00008001};
    vecs[5]  = '{op_store, 3'b001, 32'h00000202, 32'h0000ABCD, 32'h0,        1, 1'b0, 32'h00000200, 4'b1100, 32'hABCD0000, 32'h00008001};
    vecs[6]  = '{op_store, 3'b000, 32'h00000201, 32'h000000EF, 32'h0,        0, 1'b0, 32'h00000200, 4'b0010, 32'h0000EF00, 32'h00008001};
    vecs[7]  = '{op_store, 3'b010, 32'h00000300, 32'h12345678, 32'h0,        2, 1'b0, 32'h00000300, 4'b1111, 32'h12345678, 32'h00008001};
    vecs[8]  = '{op_load,  3'b010, 32'h00000101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h00008001};
    vecs[9]  = '{op_store, 3'b111, 32'h00000200, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h00008001};
    vecs[10] = '{op_load,  3'b001, 32'h00000101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h00008001};
    vecs[11] = '{op_load,  3'b011, 32'h00000100, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h00008001};

    rst = 1'b1; start = 1'b0; opcode = op_imm; funct3 = 3'b0; addr = 32'h0;
    store_data = 32'h0; mem_resp = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done | fault), 32'd0);
    check("rst strobes", 32'(mem_read | mem_write), 32'd0);
    check("rst wmask", 32'(mem_wmask), 32'd0);
    check("rst load_data", load_data, 32'h0);
    check("rst address", mem_address, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset in the middle of a read, then a stray response.
    @(negedge clk);
    start = 1'b1; opcode = op_load; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    start = 1'b0;
    check("midrst read_before", 32'(mem_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst read_drop", 32'(mem_read), 32'd0);
    check("midrst busy_drop", 32'(busy), 32'd0);
    check("midrst load_clear", load_data, 32'h0);
    check("midrst address_clear", mem_address, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_resp = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_resp = 1'b0;
    check("stray done", 32'(done), 32'd0);
    check("stray busy", 32'(busy), 32'd0);
    check("stray load", load_data, 32'h0);

    // Start pulsed while busy must be ignored and not queued.
    @(negedge clk);
    start = 1'b1; opcode = op_load; funct3 = 3'b010; addr = 32'h500;
    @(negedge clk);
    start = 1'b1; opcode = op_store; funct3 = 3'b010; addr = 32'h600; store_data = 32'h55AA55AA;
    @(negedge clk);
    start = 1'b0;
    check("busy_start read", 32'(mem_read), 32'd1);
    check("busy_start write", 32'(mem_write), 32'd0);
    check("busy_start address", mem_address, 32'h500);
    mem_resp = 1'b1; mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_resp = 1'b0;
    check("busy_start done", 32'(done), 32'd1);
    check("busy_start load", load_data, 32'h11223344);
    @(negedge clk);
    check("busy_start no_queue busy", 32'(busy), 32'd0);
    check("busy_start no_queue write", 32'(mem_write), 32'd0);

    // Non-memory opcode must leave the block idle.
    start = 1'b1; opcode = op_reg; funct3 = 3'b000; addr = 32'h700;
    @(negedge clk);
    start = 1'b0;
    check("op_reg busy", 32'(busy), 32'd0);
    check("op_reg strobes", 32'(mem_read | mem_write | done), 32'd0);
    check("op_reg load", load_data, 32'h11223344);
    check("scoreboard empty", 32'(scb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high; ports are named clk and rst.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  one-cycle request from the main control FSM; sampled only in IDLE.
REQ-005 opcode  input  7  rv32i_opcode; only op_load and op_store act on start.
REQ-006 funct3  input  3  load_funct3_t or store_funct3_t, selected by opcode.
REQ-007 addr  input  32  effective byte address from the ALU.
REQ-008 store_data  input  32  rs2 value.
REQ-009 mem_resp  input  1  memory completion; single cycle; ignored outside RD/WR.
REQ-010 mem_rdata  input  32  memory read word; valid when mem_resp=1.
REQ-011 mem_address  output  32  {addr[31:2],2'b00} of the captured request.
REQ-012 mem_read, mem_write  output  1 each  memory strobes, held until mem_resp.
REQ-013 mem_wmask  output  4  byte enables; 4'b0000 unless in WR.
REQ-014 mem_wdata  output  32  byte-lane-aligned store data.
REQ-015 load_data  output  32  extended load result; holds until the next load completes.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 fault  output  1  one-cycle pulse coincident with done for misaligned or illegal-funct3 requests.

Function
REQ-019 In IDLE, start with op_load or op_store SHALL register addr, funct3, opcode and store_data; the control FSM need not hold them.
REQ-020 States SHALL be IDLE, RD, WR, DONE and FLT.
REQ-021 Transitions from IDLE on start: legal op_load -> RD; legal op_store -> WR; misaligned or illegal funct3 -> FLT; any other opcode -> remain IDLE.
REQ-022 RD/WR SHALL remain until mem_resp=1, then go to DONE; DONE and FLT SHALL each return to IDLE after one cycle.
REQ-023 mem_read SHALL equal (state==RD) and mem_write SHALL equal (state==WR), driven from the state register only.
REQ-024 Misaligned SHALL mean: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0; lb/lbu/sb are never misaligned.
REQ-025 Illegal funct3: load 3'b011/110/111, store 3'b011-111; a faulting request SHALL never assert mem_read or mem_write.
REQ-026 mem_wmask in WR: sb 4'b0001<<addr[1:0]; sh 4'b0011<<addr[1:0]; sw 4'b1111.
REQ-027 mem_wdata SHALL be store_data<<(8*addr[1:0]).
REQ-028 On mem_resp in RD, load_data SHALL be loaded with (mem_rdata>>(8*addr[1:0])), then extended: lb/lh sign, lbu/lhu zero, lw unchanged.
REQ-029 done=1 in DONE and FLT; fault=1 only in FLT.
REQ-030 Latency: start at cycle 0 -> strobe from cycle 1 -> mem_resp at cycle k -> done at cycle k+1 (minimum 2 cycles).
REQ-031 start while busy SHALL be ignored; it is not queued.
REQ-032 mem_resp in the same cycle the strobe first rises SHALL be accepted.

Reset
REQ-033 rst SHALL immediately force IDLE; mem_read, mem_write, done, fault and busy SHALL drop to 0, mem_wmask to 0, and load_data and the captured registers to 32'h0.
REQ-034 Reset during RD/WR SHALL abandon the access, with no done; a mem_resp arriving after reset SHALL be ignored.

Structure
REQ-035 The state enum lsu_state_t SHALL be added to the shared rv32i_types package; the funct3 enums already there SHALL be reused.
REQ-036 Lane shifting and extension SHALL be a combinational sub-module lsu_align; the FSM and registers stay in lsu_ctrl.

Verification
REQ-037 lw, addr 32'h100, mem_resp after 3 wait cycles, rdata 32'hDEADBEEF -> load_data 32'hDEADBEEF; done exactly one cycle after mem_resp.
REQ-038 lb, addr 32'h103, rdata 32'h80112233 -> load_data 32'hFFFFFF80; the same access as lbu -> 32'h00000080.
REQ-039 sh, addr 32'h202, store_data 32'h0000ABCD -> mem_address 32'h200, wmask 4'b1100, wdata 32'hABCD0000.
REQ-040 lw addr 32'h101, and separately sb with funct3 3'b111 -> FLT, with done and fault high for one cycle and mem_read/mem_write never asserted.
REQ-041 rst pulsed mid-RD, then a stray mem_resp -> immediate IDLE, no done, and load_data 32'h0.
REQ-042 start pulsed while busy, and start with opcode op_reg -> no new access, and state is unaffected.
